// File: rtl/add_arb_if.sv
// Request/response bundle shared by NREQ requesters, the add_arb shared adder and its result consumer.
// slv is the arbiter side, mst the requester/consumer side.
interface add_arb_if #(
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_sum;
   logic              rsp_carry;
   logic              rsp_ready;

   modport slv (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );

   modport mst (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
   );
endinterface

// File: rtl/add_arb.sv
// Round-robin arbiter sharing one 4-bit adder: grant at N, result valid at N+2, held until rsp_ready.
// Requests are not granted while a result is pending; ADD_ARB_STATS_EN adds handshake/carry counters.
module add_arb #(
   parameter int NREQ = 4
) (
   input  logic        clk,
   input  logic        rst,
   add_arb_if.slv      bus
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [15:0] stat_ops_o,
   output logic [15:0] stat_carry_o
`endif
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] own_q, own_d;
   logic [3:0]     op_a_q, op_a_d;
   logic [3:0]     op_b_q, op_b_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [3:0]     rsp_sum_q, rsp_sum_d;
   logic           rsp_carry_q, rsp_carry_d;

   logic           found;
   logic [IDW-1:0] win;
   int             idx;
   logic [4:0]     sum5;
   logic           rsp_fire;

   // First valid requester at or after ptr, wrapping to 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   assign sum5     = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      own_d         = own_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_id_d      = rsp_id_q;
      rsp_sum_d     = rsp_sum_q;
      rsp_carry_d   = rsp_carry_q;
      bus.req_ready = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               bus.req_ready[win] = 1'b1;
               own_d   = win;
               op_a_d  = bus.req_a[4*win +: 4];
               op_b_d  = bus.req_b[4*win +: 4];
               ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_sum_d   = sum5[3:0];
            rsp_carry_d = sum5[4];
            rsp_id_d    = own_q;
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         own_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_carry_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         own_q       <= own_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_carry_q <= rsp_carry_d;
      end
   end

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_carry = rsp_carry_q;

`ifdef ADD_ARB_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d;
   logic [15:0] stat_carry_q, stat_carry_d;

   always_comb begin
      stat_ops_d   = stat_ops_q;
      stat_carry_d = stat_carry_q;
      if (rsp_fire) begin
         stat_ops_d = stat_ops_q + 16'd1;
         if (rsp_carry_q) begin
            stat_carry_d = stat_carry_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops_q   <= '0;
         stat_carry_q <= '0;
      end else begin
         stat_ops_q   <= stat_ops_d;
         stat_carry_q <= stat_carry_d;
      end
   end

   assign stat_ops_o   = stat_ops_q;
   assign stat_carry_o = stat_carry_q;
`else
   logic unused_fire;
   assign unused_fire = rsp_fire;
`endif
endmodule

// File: tb/tb_add_arb.sv
// Directed bench for add_arb: reset, single op, fairness, backpressure, async reset, exhaustive sums.
// Inputs change and outputs are sampled just after the falling edge.
module tb_add_arb;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   add_arb_if #(.NREQ(NREQ)) bus ();

`ifdef ADD_ARB_STATS_EN
   logic [15:0] stat_ops;
   logic [15:0] stat_carry;
`endif

   add_arb #(.NREQ(NREQ)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slv)
`ifdef ADD_ARB_STATS_EN
      ,
      .stat_ops_o   (stat_ops),
      .stat_carry_o (stat_carry)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_op(input int k, input logic [3:0] a, input logic [3:0] b);
      bus.req_a[4*k +: 4] = a;
      bus.req_b[4*k +: 4] = b;
   endtask

   initial begin
      logic [4:0] exp5;
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;

      // Reset takes effect before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_sum",   32'(bus.rsp_sum),   32'h0);
      check("rst_rsp_carry", 32'(bus.rsp_carry), 32'h0);
      check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);

      // Single request 3+4 from requester 0.
      step();
      rst           = 1'b0;
      bus.req_valid = 4'b0001;
      set_op(0, 4'd3, 4'd4);
      bus.rsp_ready = 1'b1;
      #1;
      check("single_grant", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      #1;
      check("single_exec_rdy", 32'(bus.req_ready), 32'h0);
      check("single_exec_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      check("single_vld",   32'(bus.rsp_valid), 32'h1);
      check("single_id",    32'(bus.rsp_id),    32'h0);
      check("single_sum",   32'(bus.rsp_sum),   32'h7);
      check("single_carry", 32'(bus.rsp_carry), 32'h0);
      step();
      check("single_done_vld", 32'(bus.rsp_valid), 32'h0);

      // Fairness: all four valid from reset, grants 0,1,2,3,0 every 3 cycles.
      rst = 1'b1;
      step();
      rst           = 1'b0;
      bus.req_valid = 4'b1111;
      for (int k = 0; k < NREQ; k++) set_op(k, 4'(k + 2), 4'(k + 10));
      bus.rsp_ready = 1'b1;
      #1;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) step();
         check("fair_grant", 32'(bus.req_ready), (c % 3 == 0) ? (32'h1 << ((c / 3) % 4)) : 32'h0);
         if (c % 3 == 2) begin
            exp5 = 5'(((c / 3) % 4) * 2 + 12);
            check("fair_vld", 32'(bus.rsp_valid), 32'h1);
            check("fair_id",  32'(bus.rsp_id),    32'((c / 3) % 4));
            check("fair_res", 32'({bus.rsp_carry, bus.rsp_sum}), 32'(exp5));
         end
      end
      step();
      bus.req_valid = '0;
      rst           = 1'b1;

      // Backpressure: 9+8 held for 5 cycles; requester 2 withdraws while waiting.
      step();
      rst           = 1'b0;
      bus.req_valid = 4'b0001;
      set_op(0, 4'd9, 4'd8);
      bus.rsp_ready = 1'b0;
      #1;
      check("bp_grant0", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = 4'b0010;
      set_op(1, 4'd1, 4'd2);
      set_op(2, 4'd5, 4'd5);
      #1;
      check("bp_exec_rdy", 32'(bus.req_ready), 32'h0);
      check("bp_exec_vld", 32'(bus.rsp_valid), 32'h0);
      for (int c = 2; c <= 6; c++) begin
         step();
         if (c == 3) bus.req_valid = 4'b0110;
         if (c == 5) bus.req_valid = 4'b0010;
         #1;
         check("bp_hold_vld",   32'(bus.rsp_valid), 32'h1);
         check("bp_hold_sum",   32'(bus.rsp_sum),   32'h1);
         check("bp_hold_carry", 32'(bus.rsp_carry), 32'h1);
         check("bp_hold_id",    32'(bus.rsp_id),    32'h0);
         check("bp_hold_rdy",   32'(bus.req_ready), 32'h0);
      end
      step();
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_hs_vld", 32'(bus.rsp_valid), 32'h1);
      check("bp_hs_rdy", 32'(bus.req_ready), 32'h0);
      step();
      check("bp_next_grant", 32'(bus.req_ready), 32'h2);
      check("bp_next_vld",   32'(bus.rsp_valid), 32'h0);
      step();
      bus.req_valid = '0;
      step();
      check("bp_r1_vld", 32'(bus.rsp_valid), 32'h1);
      check("bp_r1_id",  32'(bus.rsp_id),    32'h1);
      check("bp_r1_sum", 32'(bus.rsp_sum),   32'h3);
      step();
      check("bp_withdrawn", 32'(bus.req_ready), 32'h0);
      check("bp_idle_vld",  32'(bus.rsp_valid), 32'h0);

      // Reset during EXEC discards the result; next grant restarts at ptr=0.
      step();
      bus.req_valid = 4'b0001;
      set_op(0, 4'd1, 4'd1);
      #1;
      check("rx_grant", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      rst           = 1'b1;
      #1;
      check("rx_async_sum", 32'(bus.rsp_sum),   32'h0);
      check("rx_async_id",  32'(bus.rsp_id),    32'h0);
      check("rx_async_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      check("rx_hold_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      rst           = 1'b0;
      bus.req_valid = 4'b0100;
      set_op(2, 4'd2, 4'd5);
      bus.rsp_ready = 1'b0;
      #1;
      check("rx_grant2", 32'(bus.req_ready), 32'h4);
      check("rx_no_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      bus.req_valid = '0;
      #1;
      check("rx_exec_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      check("rx_vld", 32'(bus.rsp_valid), 32'h1);
      check("rx_id",  32'(bus.rsp_id),    32'h2);
      check("rx_sum", 32'(bus.rsp_sum),   32'h7);
      // Reset while the result is waiting drops rsp_valid at once.
      rst = 1'b1;
      #1;
      check("rx_resp_async_vld", 32'(bus.rsp_valid), 32'h0);
      step();
      rst           = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;
      check("rx_discarded_vld", 32'(bus.rsp_valid), 32'h0);
`ifdef ADD_ARB_STATS_EN
      check("stat_ops_rst",   32'(stat_ops),   32'h0);
      check("stat_carry_rst", 32'(stat_carry), 32'h0);
`endif

      // Exhaustive sums through requester 1.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            step();
            bus.req_valid = 4'b0010;
            set_op(1, 4'(i), 4'(j));
            #1;
            check("exh_grant", 32'(bus.req_ready), 32'h2);
            step();
            bus.req_valid = '0;
            step();
            exp5 = 5'(i + j);
            check("exh_res", 32'({bus.rsp_carry, bus.rsp_sum}), 32'(exp5));
            check("exh_id",  32'(bus.rsp_id), 32'h1);
         end
      end
      step();
      check("exh_idle_vld", 32'(bus.rsp_valid), 32'h0);
`ifdef ADD_ARB_STATS_EN
      check("stat_ops",   32'(stat_ops),   32'd256);
      check("stat_carry", 32'(stat_carry), 32'd120);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
